// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor family: counter constants,
// saturating counter steps and PC index/tag extraction.
package bp_pkg;

   // Weakly-taken value: the lowest counter value with the MSB set.
   function automatic int unsigned weak_t(input int unsigned ctr_bits);
      return 32'd1 << (ctr_bits - 32'd1);
   endfunction

   // Weakly-not-taken value: the highest counter value with the MSB clear.
   function automatic int unsigned weak_nt(input int unsigned ctr_bits);
      return weak_t(ctr_bits) - 32'd1;
   endfunction

   // Saturating increment, clamped at 2^ctr_bits - 1.
   function automatic int unsigned sat_inc(input int unsigned v, input int unsigned ctr_bits);
      int unsigned max_v;
      max_v = (32'd1 << ctr_bits) - 32'd1;
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

   // Saturating decrement, clamped at zero.
   function automatic int unsigned sat_dec(input int unsigned v);
      return (v == 32'd0) ? 32'd0 : v - 32'd1;
   endfunction

   // Entry index: word-aligned PC bits directly above the byte offset.
   function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned idx_bits);
      return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
   endfunction

   // Tag: every PC bit above the index field.
   function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_bits);
      return pc >> (idx_bits + 32'd2);
   endfunction

endpackage

// File: rtl/bp_redirect_check.sv
// Resolution check shared by the BTB and BHT/gshare predictors:
// flags a mispredicted branch and supplies the corrected next PC.
module bp_redirect_check #(
   parameter int unsigned XLEN = 32
) (
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [XLEN-1:0] upd_pred_target,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc
);

   logic dir_wrong_s;
   logic tgt_wrong_s;

   // Compare the carried prediction with the actual outcome.
   always_comb begin
      dir_wrong_s = (upd_taken != upd_pred_taken);
      tgt_wrong_s = upd_taken && upd_pred_taken && (upd_target != upd_pred_target);
      mispredict  = upd_valid && (dir_wrong_s || tgt_wrong_s);
      if (upd_taken) begin
         redirect_pc = upd_target;
      end else begin
         redirect_pc = upd_pc + XLEN'(3'd4);
      end
   end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Lookup is combinational from registered state (no update bypass);
// training happens on the clock edge from MEM-stage resolution.
module branch_predictor_btb
   import bp_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ENTRIES  = 16,
   parameter int unsigned CTR_BITS = 2,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  lookup_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [XLEN-1:0]  pred_target,
   input  logic             upd_valid,
   input  logic [XLEN-1:0]  upd_pc,
   input  logic             upd_taken,
   input  logic [XLEN-1:0]  upd_target,
   input  logic             upd_pred_taken,
   input  logic [XLEN-1:0]  upd_pred_target,
   output logic             mispredict,
   output logic [XLEN-1:0]  redirect_pc,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam int unsigned IDX_BITS = $clog2(ENTRIES);
   localparam int unsigned TAG_BITS = XLEN - IDX_BITS - 2;
   localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(weak_t(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'(weak_nt(CTR_BITS));
   localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};

   logic                valid_r  [ENTRIES];
   logic [TAG_BITS-1:0] tag_r    [ENTRIES];
   logic [XLEN-1:0]     target_r [ENTRIES];
   logic [CTR_BITS-1:0] ctr_r    [ENTRIES];

   logic [IDX_BITS-1:0] lk_idx_s;
   logic [TAG_BITS-1:0] lk_tag_s;
   logic [IDX_BITS-1:0] up_idx_s;
   logic [TAG_BITS-1:0] up_tag_s;
   logic                up_hit_s;
   logic [CTR_BITS-1:0] ctr_next_s;
   logic                mispredict_s;
   logic [CNT_W-1:0]    branch_cnt_r;
   logic [CNT_W-1:0]    mispredict_cnt_r;

   bp_redirect_check #(.XLEN(XLEN)) u_redirect_check (
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .mispredict      (mispredict_s),
      .redirect_pc     (redirect_pc)
   );

   assign mispredict     = mispredict_s;
   assign branch_cnt     = branch_cnt_r;
   assign mispredict_cnt = mispredict_cnt_r;

   // IF-stage lookup: hit, direction from counter MSB, fall-through on not-taken.
   always_comb begin
      lk_idx_s   = IDX_BITS'(pc_index(64'(lookup_pc), IDX_BITS));
      lk_tag_s   = TAG_BITS'(pc_tag(64'(lookup_pc), IDX_BITS));
      pred_hit   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
      pred_taken = pred_hit && ctr_r[lk_idx_s][CTR_BITS-1];
      if (pred_taken) begin
         pred_target = target_r[lk_idx_s];
      end else begin
         pred_target = lookup_pc + XLEN'(3'd4);
      end
   end

   // Training decode: locate the resolving branch's entry and its next counter value.
   always_comb begin
      up_idx_s = IDX_BITS'(pc_index(64'(upd_pc), IDX_BITS));
      up_tag_s = TAG_BITS'(pc_tag(64'(upd_pc), IDX_BITS));
      up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
      if (upd_taken) begin
         ctr_next_s = CTR_BITS'(sat_inc(32'(ctr_r[up_idx_s]), CTR_BITS));
      end else begin
         ctr_next_s = CTR_BITS'(sat_dec(32'(ctr_r[up_idx_s])));
      end
   end

   // BTB state: reset wins over a coincident update; a taken miss allocates.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_r[i]  <= 1'b0;
            tag_r[i]    <= '0;
            target_r[i] <= '0;
            ctr_r[i]    <= CTR_WEAK_NT;
         end
      end else if (upd_valid) begin
         if (up_hit_s) begin
            ctr_r[up_idx_s] <= ctr_next_s;
            if (upd_taken) begin
               target_r[up_idx_s] <= upd_target;
            end
         end else if (upd_taken) begin
            valid_r[up_idx_s]  <= 1'b1;
            tag_r[up_idx_s]    <= up_tag_s;
            target_r[up_idx_s] <= upd_target;
            ctr_r[up_idx_s]    <= CTR_WEAK_T;
         end
      end
   end

   // Performance counters, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         branch_cnt_r     <= '0;
         mispredict_cnt_r <= '0;
      end else if (upd_valid) begin
         if (branch_cnt_r != CNT_MAX) begin
            branch_cnt_r <= branch_cnt_r + CNT_W'(1'b1);
         end
         if (mispredict_s && (mispredict_cnt_r != CNT_MAX)) begin
            mispredict_cnt_r <= mispredict_cnt_r + CNT_W'(1'b1);
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed walk through the
// predictor's main scenarios followed by randomized traffic, all compared
// against an entry-level behavioural model kept in the bench.
module tb_branch_predictor_btb;

   localparam int ENTRIES  = 16;
   localparam int CTR_BITS = 2;
   localparam int CNT_W    = 4;
   localparam int CTR_MAX  = 3;
   localparam int CNT_MAX  = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] lookup_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        upd_pred_taken;
   logic [31:0] upd_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [3:0]  branch_cnt;
   logic [3:0]  mispredict_cnt;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: one record per BTB slot, counters as plain integers.
   bit          m_valid  [ENTRIES];
   logic [31:0] m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_ctr    [ENTRIES];
   int          m_bc;
   int          m_mc;
   bit          m_init = 1'b0;

   branch_predictor_btb #(
      .XLEN(32), .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .CNT_W(CNT_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .lookup_pc       (lookup_pc),
      .pred_hit        (pred_hit),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc),
      .branch_cnt      (branch_cnt),
      .mispredict_cnt  (mispredict_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive after the falling edge, check combinational
   // outputs before the rising edge, then advance the model past the edge.
   task automatic cyc(input logic [31:0] lk, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input bit upt,
                      input logic [31:0] uptgt, input bit rst);
      int          li;
      int          ui;
      bit          e_hit;
      bit          e_tk;
      bit          e_mp;
      logic [31:0] e_tgt;
      logic [31:0] e_rd;
      @(negedge clk);
      lookup_pc       = lk;
      upd_valid       = uv;
      upd_pc          = upc;
      upd_taken       = ut;
      upd_target      = utgt;
      upd_pred_taken  = upt;
      upd_pred_target = uptgt;
      reset           = rst;
      #1;
      li = int'((lk / 32'd4) % 32'd16);
      ui = int'((upc / 32'd4) % 32'd16);
      if (m_init) begin
         e_hit = m_valid[li] && (m_tag[li] == lk / 32'd64);
         e_tk  = e_hit && (m_ctr[li] >= 2);
         e_tgt = e_tk ? m_target[li] : lk + 32'd4;
         check("pred_hit", 64'(pred_hit), 64'(e_hit));
         check("pred_taken", 64'(pred_taken), 64'(e_tk));
         check("pred_target", 64'(pred_target), 64'(e_tgt));
         check("branch_cnt", 64'(branch_cnt), 64'(m_bc));
         check("mispredict_cnt", 64'(mispredict_cnt), 64'(m_mc));
      end
      if (!uv) e_mp = 1'b0;
      else if (ut != upt) e_mp = 1'b1;
      else e_mp = ut && (utgt != uptgt);
      e_rd = ut ? utgt : upc + 32'd4;
      check("mispredict", 64'(mispredict), 64'(e_mp));
      check("redirect_pc", 64'(redirect_pc), 64'(e_rd));
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 32'd0;
            m_target[i] = 32'd0;
            m_ctr[i]    = 1;
         end
         m_bc   = 0;
         m_mc   = 0;
         m_init = 1'b1;
      end else if (uv) begin
         if (m_valid[ui] && (m_tag[ui] == upc / 32'd64)) begin
            if (ut) begin
               m_ctr[ui]    = (m_ctr[ui] == CTR_MAX) ? CTR_MAX : m_ctr[ui] + 1;
               m_target[ui] = utgt;
            end else begin
               m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
            end
         end else if (ut) begin
            m_valid[ui]  = 1'b1;
            m_tag[ui]    = upc / 32'd64;
            m_target[ui] = utgt;
            m_ctr[ui]    = 2;
         end
         m_bc = (m_bc == CNT_MAX) ? CNT_MAX : m_bc + 1;
         if (e_mp) m_mc = (m_mc == CNT_MAX) ? CNT_MAX : m_mc + 1;
      end
   endtask

   // Small PC pool so random traffic aliases and re-hits entries often.
   function automatic logic [31:0] rpc();
      if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
      return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
   endfunction

   initial begin
      bit          uv;
      bit          ut;
      bit          upt;
      logic [31:0] upc;
      logic [31:0] utgt;
      logic [31:0] uptgt;
      logic [31:0] lk;

      // Reset, then an idle lookup of 0x40.
      cyc(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      cyc(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      cyc(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      // Taken miss allocates at weakly-taken; redirect to 0x80.
      cyc(32'h40,  1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
      cyc(32'h100, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0, 1'b0);
      // Three not-taken resolves saturate the counter at zero.
      for (int k = 0; k < 3; k++)
         cyc(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cyc(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      // Alias at index 0 with a different tag, then a wrong-target resolve.
      cyc(32'h100, 1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
      cyc(32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b0);
      cyc(32'h140, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b0);
      cyc(32'h140, 1'b1, 32'h140, 1'b1, 32'h200, 1'b1, 32'h80, 1'b0);
      // Same-cycle lookup and update: no bypass.
      cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0,  1'b0);
      cyc(32'h100, 1'b1, 32'h100, 1'b0, 32'h0,  1'b0, 32'h0,  1'b0);
      cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
      cyc(32'h100, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0,  1'b0);
      // PC wrap at the top of the address space.
      cyc(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
      // Counter saturation, then reset coinciding with an update.
      for (int k = 0; k < 20; k++)
         cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
      cyc(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
      cyc(32'h100, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h0, 1'b0);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         uv    = ($urandom_range(0, 3) != 0);
         upc   = rpc();
         ut    = 1'($urandom_range(0, 1));
         utgt  = rpc();
         upt   = 1'($urandom_range(0, 1));
         uptgt = ($urandom_range(0, 1) == 0) ? utgt : rpc();
         lk    = ($urandom_range(0, 1) == 0) ? upc : rpc();
         cyc(lk, uv, upc, ut, utgt, upt, uptgt, ($urandom_range(0, 99) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised branch predictor for the 5-stage pipeline: a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Predicts next PC in IF; branches currently resolve in MEM with an implicit predict-not-taken.
- Trained from MEM-stage resolution; produces mispredict/redirect for the IF PC mux and the flush logic.
- Includes saturating performance counters.

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, number of BTB entries; power of two, >= 2.
- CTR_BITS, 2, direction counter width; >= 1.
- CNT_W, 32, performance counter width.
- Derived: IDX_BITS = log2(ENTRIES); index = pc[IDX_BITS+1:2]; tag = pc[XLEN-1:IDX_BITS+2].

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- lookup_pc  in  XLEN  PC_IF.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  predicted taken.
- pred_target  out  XLEN  predicted next PC.
- upd_valid  in  1  a branch resolves in MEM this cycle.
- upd_pc  in  XLEN  PC of the resolving branch.
- upd_taken  in  1  actual outcome (ZERO_MEM & Branch_MEM).
- upd_target  in  XLEN  actual target (PC_Branch_MEM).
- upd_pred_taken  in  1  prediction carried down the pipeline with the branch.
- upd_pred_target  in  XLEN  prediction carried down the pipeline with the branch.
- mispredict  out  1  flush IF/ID/EX and redirect.
- redirect_pc  out  XLEN  correct next PC.
- branch_cnt  out  CNT_W  resolved branches.
- mispredict_cnt  out  CNT_W  mispredictions.

Behaviour:
- State per entry: valid, tag, target[XLEN], ctr[CTR_BITS].
- Constants: WEAK_T = 2^(CTR_BITS-1); WEAK_NT = WEAK_T-1.
- Reset (sync, one edge), applies even mid-update; update in the same cycle is discarded:
  - all valid=0, ctr=WEAK_NT, target=0.
  - branch_cnt=0, mispredict_cnt=0.
- Lookup is combinational from registered state; zero latency.
  - pred_hit = valid[idx] & tag match.
  - pred_taken = pred_hit & ctr[idx][MSB].
  - pred_target = pred_taken ? target[idx] : lookup_pc+4.
  - During reset cycle: outputs computed from current state (not forced).
- mispredict is combinational, 0 when upd_valid=0.
  - mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - redirect_pc is don't-care when mispredict=0 but must still follow the formula.
- Update on clk edge when upd_valid=1 and reset=0:
  - Hit (valid & tag match at upd_pc index): ctr saturating +1 if taken, -1 if not, clamped to [0, 2^CTR_BITS-1]; target<=upd_target if taken.
  - Miss and taken: allocate/replace the entry: valid=1, tag, target=upd_target, ctr=WEAK_T.
  - Miss and not taken: no change.
- Same-cycle lookup and update to the same index: lookup returns pre-update state, no bypass. New state is visible the next cycle.
- Performance counters, updated on the clock edge when upd_valid=1:
  - branch_cnt += 1.
  - mispredict_cnt += mispredict.
  - Both saturate at all-ones; no wrap.
- PC +4 arithmetic is modulo 2^XLEN: 0xFFFFFFFC+4 = 0.
- Registers written only on clk; no latches; no reset-to-X.

Decomposition:
- Shared package bp_pkg: WEAK_T/WEAK_NT constant functions of CTR_BITS; sat_inc/sat_dec functions; index/tag extraction functions.
- One natural sub-module: bp_redirect_check. Purely combinational; computes mispredict and redirect_pc. Reused by the later BHT/gshare variant.

Test Plan (ENTRIES=16, CTR_BITS=2, CNT_W=4):
1. After reset, lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44; branch_cnt=0.
2. Update pc=0x100, taken=1, target=0x80, pred_taken=0 -> same cycle: mispredict=1, redirect_pc=0x80. Next cycle, lookup 0x100 -> hit=1, taken=1 (ctr=2), target=0x80.
3. Three not-taken updates at 0x100 -> ctr 2->1->0->0; lookup taken=0, target=0x104. Not-taken resolve with pred_taken=0 -> mispredict=0.
4. Alias: taken update pc=0x140 (index 0, different tag) with target=0x200 -> lookup 0x100 hit=0; lookup 0x140 target=0x200, taken=1. Taken update with correct direction but wrong target (pred 0x80, actual 0x200) -> mispredict=1.
5. Same-cycle lookup 0x100 with taken update at 0x100 from ctr=1 -> lookup taken=0 that cycle, taken=1 next cycle.
6. 20 mispredicting updates -> mispredict_cnt=15 (saturated). Reset asserted with upd_valid=1 -> next cycle all counters 0, lookup 0x100 hit=0.
